mrd_stage_seq: RTL

Stage sequencer for the mixed-radix DFT memory datapath. It consumes the per-packet factorisation parameters produced by the top control FSM: number of factors, radix per stage, groups per stage, twiddle denominators and radix-2 stage. It then walks every PFA/CTA stage, emitting one (stage, group, point, twiddle exponent) tuple per memory read under a valid/ready handshake. Between stages it waits for the write-back path to report completion.

---
 rtl/mrd_stage_seq.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mrd_stage_seq.sv
`default_nettype none
// ============================================================================
// Module   : mrd_stage_seq
// Purpose  : Mixed-radix DFT stage sequencer; emits one (stage, group, point,
//            twiddle exponent) read tuple per valid/ready handshake.
// Options  : MRD_SEQ_TWDL_EN builds the twiddle-exponent generator.
// Revision : 1.0
// ============================================================================
module mrd_stage_seq #(
    parameter int PTS_W   = 12,
    parameter int MAX_STG = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               num_factors,
    input  logic [MAX_STG*3-1:0]     nf,
    input  logic [MAX_STG*PTS_W-1:0] dftpts_div_nf,
    input  logic [MAX_STG*PTS_W-1:0] twdl_demontr,
    input  logic [2:0]               stage_of_rdx2,
    input  logic                     wr_done,
    output logic                     busy,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [2:0]               rd_stage,
    output logic [PTS_W-1:0]         rd_grp,
    output logic [2:0]               rd_pt,
    output logic [PTS_W-1:0]         rd_twdl_exp,
    output logic                     rd_is_rdx2,
    output logic                     rd_last,
    output logic                     stage_done,
    output logic                     all_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [PTS_W-1:0] c_one_pts = {{(PTS_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [2:0]       r_num_factors;
    logic [2:0]       r_rdx2;
    logic [2:0]       r_nf_a  [MAX_STG];
    logic [PTS_W-1:0] r_grp_a [MAX_STG];
    logic [2:0]       r_stage;
    logic [PTS_W-1:0] r_grp;
    logic [2:0]       r_pt;
    logic             r_stage_done;

    logic [2:0]       w_nf_cur;
    logic [PTS_W-1:0] w_grps_cur;
    logic [2:0]       w_stage_inc;
    logic             w_start_acc;
    logic             w_wr_acc;
    logic             w_acc;
    logic             w_pt_end;
    logic             w_grp_end;
    logic             w_final;

    assign w_nf_cur    = r_nf_a[r_stage];
    assign w_grps_cur  = r_grp_a[r_stage];
    assign w_stage_inc = r_stage + 3'd1;
    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_wr_acc    = (r_state == S_WAIT) && wr_done;
    assign w_acc       = (r_state == S_RD) && rd_ready;
    assign w_pt_end    = (r_pt == w_nf_cur - 3'd1);
    assign w_grp_end   = (r_grp == w_grps_cur - c_one_pts);
    assign w_final     = w_acc && w_pt_end && w_grp_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_num_factors <= 3'd0;
            r_rdx2        <= 3'd7;
            r_stage       <= 3'd0;
            r_grp         <= '0;
            r_pt          <= 3'd0;
            r_stage_done  <= 1'b0;
            for (int s = 0; s < MAX_STG; s++) begin
                r_nf_a[s]  <= 3'd0;
                r_grp_a[s] <= '0;
            end
        end else begin
            r_stage_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num_factors <= num_factors;
                        r_rdx2        <= stage_of_rdx2;
                        for (int s = 0; s < MAX_STG; s++) begin
                            r_nf_a[s]  <= nf[3*s +: 3];
                            r_grp_a[s] <= dftpts_div_nf[PTS_W*s +: PTS_W];
                        end
                        r_stage <= 3'd0;
                        r_grp   <= '0;
                        r_pt    <= 3'd0;
                        r_state <= (num_factors == 3'd0) ? S_DONE : S_RD;
                    end
                end
                S_RD: begin
                    if (w_final) begin
                        // Counters hold on the last tuple; they clear when write-back finishes.
                        r_stage_done <= 1'b1;
                        r_state      <= S_WAIT;
                    end else if (w_acc) begin
                        if (w_pt_end) begin
                            r_pt  <= 3'd0;
                            r_grp <= r_grp + c_one_pts;
                        end else begin
                            r_pt <= r_pt + 3'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (wr_done) begin
                        r_stage <= w_stage_inc;
                        r_grp   <= '0;
                        r_pt    <= 3'd0;
                        r_state <= (w_stage_inc == r_num_factors) ? S_DONE : S_RD;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MRD_SEQ_TWDL_EN
    logic [PTS_W-1:0] r_den_a [MAX_STG];
    logic [PTS_W-1:0] r_k;
    logic [PTS_W-1:0] r_exp;
    logic [PTS_W-1:0] w_den_nxt;

    // k tracks grp mod the next stage's denominator; exp accumulates pt*k.
    assign w_den_nxt = r_den_a[w_stage_inc];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k   <= '0;
            r_exp <= '0;
            for (int s = 0; s < MAX_STG; s++) begin
                r_den_a[s] <= '0;
            end
        end else begin
            if (w_start_acc) begin
                for (int s = 0; s < MAX_STG; s++) begin
                    r_den_a[s] <= twdl_demontr[PTS_W*s +: PTS_W];
                end
            end
            if (w_start_acc || w_wr_acc) begin
                r_k   <= '0;
                r_exp <= '0;
            end else if (w_acc && !w_final) begin
                if (w_pt_end) begin
                    r_exp <= '0;
                    r_k   <= (r_k == w_den_nxt - c_one_pts) ? '0 : r_k + c_one_pts;
                end else begin
                    r_exp <= r_exp + r_k;
                end
            end
        end
    end

    assign rd_twdl_exp = r_exp;
`else
    logic w_unused_twdl;
    assign w_unused_twdl = ^twdl_demontr;
    assign rd_twdl_exp   = '0;
`endif

    assign busy       = (r_state != S_IDLE);
    assign rd_valid   = (r_state == S_RD);
    assign all_done   = (r_state == S_DONE);
    assign stage_done = r_stage_done;
    assign rd_stage   = r_stage;
    assign rd_grp     = r_grp;
    assign rd_pt      = r_pt;
    assign rd_last    = rd_valid && w_pt_end && w_grp_end;
    assign rd_is_rdx2 = rd_valid && (r_stage == r_rdx2);

endmodule
`default_nettype wire
